alu_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 16-bit adder ALU between N requesters. Each requester presents an operand pair with a valid/ready handshake. The block latches the winning operands and drives them to the ALU for one cycle. It then registers the 16-bit result and the five ALU flags, and holds them as a response to the winning requester until that requester accepts it.

---
 rtl/alu_rr_arbiter_if.sv | 38 +++
 rtl/alu_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the shared-adder arbiter.
// Latency: none (pure wiring); the arbiter defines all timing.
// Backpressure: req_valid/req_ready for operands, rsp_valid/rsp_ready for results.
interface alu_rr_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);
  // Requester operand side
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_x;
  logic [16*N-1:0]   req_y;
  logic [N-1:0]      req_ready;
  // Response side
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_z;
  logic [4:0]        rsp_flags;
  // Shared ALU side
  logic [15:0]       alu_x;
  logic [15:0]       alu_y;
  logic [15:0]       alu_z;
  logic [4:0]        alu_flags;
  // Status
  logic [15:0]       op_count;

  // Arbiter view
  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, alu_z, alu_flags,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags, alu_x, alu_y, op_count
  );

  // Requester/ALU view
  modport master (
    output req_valid, req_x, req_y, rsp_ready, alu_z, alu_flags,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags, alu_x, alu_y, op_count
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one 16-bit adder ALU among N requesters; IDLE->EXEC->RESP sequencer.
// Latency: grant in T, ALU driven in T+1, response valid from T+2; best case one op per 3 cycles.
// Backpressure: no grants outside IDLE; RESP holds frozen outputs until the owner's rsp_ready.
module alu_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [N-1:0]    ONE_HOT0 = N'(1);
  localparam logic [ID_W:0]   N_CNT    = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N-1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     op_x_q, op_x_d;
  logic [15:0]     op_y_q, op_y_d;
  logic [15:0]     rsp_z_q, rsp_z_d;
  logic [4:0]      rsp_flags_q, rsp_flags_d;
  logic [15:0]     op_count_q, op_count_d;

  logic [2*N-1:0]  valid_dbl;
  logic [N-1:0]    valid_rot;
  logic [ID_W-1:0] win_off;
  logic [ID_W:0]   win_sum;
  logic [ID_W-1:0] win_id;
  logic            win_vld;

  logic [N-1:0]    req_ready_c;
  logic [N-1:0]    rsp_valid_c;

  // Round-robin winner: rotate valids so ptr sits at bit 0, take the lowest set bit, un-rotate mod N
  always_comb begin
    valid_dbl = {bus.req_valid, bus.req_valid};
    valid_rot = valid_dbl[ptr_q +: N];
    win_vld   = 1'b0;
    win_off   = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        win_vld = 1'b1;
        win_off = ID_W'(k);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= N_CNT) begin
      win_sum = win_sum - N_CNT;
    end
    win_id = win_sum[ID_W-1:0];
  end

  // Sequencer next-state, datapath next values and handshake outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    rsp_z_d     = rsp_z_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d  = op_count_q;
    req_ready_c = '0;
    rsp_valid_c = '0;
    case (state_q)
      IDLE: begin
        // The winner is only ever a requester with valid high, so the grant is the handshake
        if (win_vld) begin
          req_ready_c = ONE_HOT0 << win_id;
          op_x_d      = bus.req_x[{win_id, 4'h0} +: 16];
          op_y_d      = bus.req_y[{win_id, 4'h0} +: 16];
          rsp_id_d    = win_id;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        rsp_z_d     = bus.alu_z;
        rsp_flags_d = bus.alu_flags;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_c = ONE_HOT0 << rsp_id_q;
        // Only the owner's ready bit matters; others are ignored
        if (bus.rsp_ready[rsp_id_q]) begin
          op_count_d = op_count_q + 16'd1;
          ptr_d      = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + ID_W'(1);
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer, captured operands, registered result and transaction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      rsp_z_q     <= rsp_z_d;
      rsp_flags_q <= rsp_flags_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_flags = rsp_flags_q;
  // The ALU sees the captured operands in every state, not only in EXEC
  assign bus.alu_x     = op_x_q;
  assign bus.alu_y     = op_y_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural 16-bit adder ALU.
// Latency: checks grant in T, ALU drive in T+1, response in T+2, IDLE in T+3.
// Backpressure: exercises a 5-cycle rsp_ready stall and mid-transaction reset.
module tb_alu_rr_arbiter;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;
  int   fail_cnt;

  alu_rr_arbiter_if #(.N(4), .ID_W(2)) bus ();

  alu_rr_arbiter #(.N(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference adder ALU: flags {Sign, Carry, Zero, Parity(odd), Overflow}
  logic [16:0] alu_sum;
  assign alu_sum       = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
  assign bus.alu_z     = alu_sum[15:0];
  assign bus.alu_flags = {alu_sum[15], alu_sum[16], (alu_sum[15:0] == 16'h0000), ^alu_sum[15:0],
                          (bus.alu_x[15] == bus.alu_y[15]) && (alu_sum[15] != bus.alu_x[15])};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    fail_cnt = 0;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.rsp_ready  = '0;
    tick();
    tick();
    #1;
    // Reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_z", 32'(bus.rsp_z), 32'h0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_alu_x", 32'(bus.alu_x), 32'h0);
    chk("rst_op_count", 32'(bus.op_count), 32'h0);
    rst_n = 1'b1;
    tick();

    // r0: 0x7FFF + 0x0001
    bus.req_x[15:0] = 16'h7FFF;
    bus.req_y[15:0] = 16'h0001;
    bus.req_valid   = 4'b0001;
    bus.rsp_ready   = 4'b1111;
    #1;
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_exec_alu_x", 32'(bus.alu_x), 32'h7FFF);
    chk("t1_exec_alu_y", 32'(bus.alu_y), 32'h0001);
    chk("t1_exec_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_exec_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    #1;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_z", 32'(bus.rsp_z), 32'h8000);
    chk("t1_rsp_flags", 32'(bus.rsp_flags), 32'b10011);
    chk("t1_rsp_id", 32'(bus.rsp_id), 32'h0);
    tick();
    #1;
    chk("t1_op_count", 32'(bus.op_count), 32'h1);
    chk("t1_idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);

    // r1: 0xFFFF + 0x0001
    bus.req_x[31:16] = 16'hFFFF;
    bus.req_y[31:16] = 16'h0001;
    bus.req_valid    = 4'b0010;
    #1;
    chk("t2_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t2_rsp_z", 32'(bus.rsp_z), 32'h0000);
    chk("t2_rsp_flags", 32'(bus.rsp_flags), 32'b01100);
    chk("t2_rsp_id", 32'(bus.rsp_id), 32'h1);
    tick();
    #1;
    chk("t2_op_count", 32'(bus.op_count), 32'h2);

    // Reset in IDLE to bring ptr and op_count back to 0
    rst_n = 1'b0;
    #1;
    chk("rst2_op_count", 32'(bus.op_count), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // All four valid, rsp_ready high: grants 0,1,2,3,0,1 every 3 cycles
    for (int i = 0; i < 4; i++) begin
      bus.req_x[16*i +: 16] = 16'(16'h0100 * (i + 1));
      bus.req_y[16*i +: 16] = 16'h0011;
    end
    bus.req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("rr_grant_%0d", t), 32'(bus.req_ready), 32'(4'b0001 << (t % 4)));
      tick();
      #1;
      tick();
      #1;
      chk($sformatf("rr_rsp_id_%0d", t), 32'(bus.rsp_id), 32'(t % 4));
      chk($sformatf("rr_rsp_z_%0d", t), 32'(bus.rsp_z), 32'(16'h0100 * ((t % 4) + 1) + 16'h0011));
      tick();
      #1;
    end
    chk("rr_op_count_6", 32'(bus.op_count), 32'h6);

    // ptr is now 2; r0 alone moves it to 1
    bus.req_valid = 4'b0001;
    #1;
    chk("ptr1_setup_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    #1;
    chk("ptr1_setup_op_count", 32'(bus.op_count), 32'h7);

    // ptr=1 with r0 and r2 valid: r2 first; then stall its response 5 cycles
    bus.req_x[15:0]  = 16'h8000;
    bus.req_y[15:0]  = 16'h8000;
    bus.req_x[47:32] = 16'h0003;
    bus.req_y[47:32] = 16'h0004;
    bus.req_valid    = 4'b0101;
    bus.rsp_ready    = 4'b1011;
    #1;
    chk("skip_grant_r2", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0001;
    #1;
    chk("skip_exec_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    #1;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("stall_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'h4);
      chk($sformatf("stall_rsp_z_%0d", k), 32'(bus.rsp_z), 32'h0007);
      chk($sformatf("stall_rsp_flags_%0d", k), 32'(bus.rsp_flags), 32'b00010);
      chk($sformatf("stall_rsp_id_%0d", k), 32'(bus.rsp_id), 32'h2);
      chk($sformatf("stall_req_ready_%0d", k), 32'(bus.req_ready), 32'h0);
      tick();
      #1;
    end
    bus.rsp_ready = 4'b0100;
    #1;
    chk("stall_accept_cycle_valid", 32'(bus.rsp_valid), 32'h4);
    chk("stall_op_count_hold", 32'(bus.op_count), 32'h7);
    tick();
    bus.rsp_ready = 4'b1111;
    #1;
    chk("wrap_grant_r0", 32'(bus.req_ready), 32'h1);
    chk("stall_op_count", 32'(bus.op_count), 32'h8);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    chk("wrap_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("wrap_rsp_z", 32'(bus.rsp_z), 32'h0000);
    chk("wrap_rsp_flags", 32'(bus.rsp_flags), 32'b01101);
    tick();
    #1;
    chk("wrap_op_count", 32'(bus.op_count), 32'h9);

    // Reset while in EXEC aborts the transaction
    bus.req_x[47:32] = 16'h00AA;
    bus.req_y[47:32] = 16'h0055;
    bus.req_valid    = 4'b0100;
    #1;
    chk("abort_grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("abort_exec_alu_x", 32'(bus.alu_x), 32'h00AA);
    rst_n = 1'b0;
    #1;
    chk("abort_alu_x", 32'(bus.alu_x), 32'h0);
    chk("abort_alu_y", 32'(bus.alu_y), 32'h0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'h0);
    chk("abort_rsp_z", 32'(bus.rsp_z), 32'h0);
    chk("abort_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    chk("abort_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("abort_op_count", 32'(bus.op_count), 32'h0);
    tick();
    tick();
    #1;
    chk("abort_hold_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // r3 alone after reset release
    bus.req_x[63:48] = 16'h1234;
    bus.req_y[63:48] = 16'h4321;
    bus.req_valid    = 4'b1000;
    #1;
    chk("r3_grant", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    chk("r3_rsp_valid", 32'(bus.rsp_valid), 32'h8);
    chk("r3_rsp_z", 32'(bus.rsp_z), 32'h5555);
    chk("r3_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    chk("r3_rsp_id", 32'(bus.rsp_id), 32'h3);
    chk("r3_op_count_pending", 32'(bus.op_count), 32'h0);
    tick();
    #1;
    chk("r3_op_count", 32'(bus.op_count), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
